// File: rtl/hp_fp_pkg.sv
// hp_fp_pkg: half-precision field widths, exception codes, FSM states and operand classification,
// shared by the half-precision multiplier and divider.
package hp_fp_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;
  localparam int QBITS = 12;
  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_OVF  = 2'b01,
    EXC_UNF  = 2'b10,
    EXC_INV  = 2'b11
  } hp_exc_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_NORM,
    S_DONE
  } hp_state_t;
  typedef struct packed {
    logic zero;
    logic denorm;
    logic inf;
    logic nan;
  } hp_class_t;
  function automatic hp_class_t hp_classify(input logic [15:0] x);
    hp_class_t c;
    logic exp_zero, exp_max, man_zero;
    exp_zero = x[14:10] == '0;
    exp_max  = x[14:10] == '1;
    man_zero = x[MAN_W-1:0] == '0;
    c.zero   = exp_zero && man_zero;
    c.denorm = exp_zero && !man_zero;
    c.inf    = exp_max && man_zero;
    c.nan    = exp_max && !man_zero;
    return c;
  endfunction
endpackage

// File: rtl/hp_sig_divider.sv
// hp_sig_divider: restoring divider of two 11-bit significands (hidden bit set), one quotient bit
// per cycle, producing QBITS bits = floor(man_a / man_b * 2^(QBITS-1)).
module hp_sig_divider
  import hp_fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [MAN_W-1:0] man_a_i,
  input  logic [MAN_W-1:0] man_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [QBITS-1:0] q_o
);
  logic [11:0]      rem_q, rem_d, diff;
  logic [10:0]      d_q, d_d;
  logic [QBITS-1:0] q_q, q_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d, ge;
  assign ge     = rem_q >= {1'b0, d_q};
  assign diff   = ge ? rem_q - {1'b0, d_q} : rem_q;
  assign done_o = busy_q && cnt_q == 4'(QBITS - 1);
  assign busy_o = busy_q;
  assign q_o    = q_q;
  // remainder after subtraction is below the divisor, so bit 11 is free to drop on the shift
  always_comb begin
    rem_d  = start_i ? {2'b01, man_a_i} : busy_q ? {diff[10:0], 1'b0} : rem_q;
    d_d    = start_i ? {1'b1, man_b_i} : d_q;
    q_d    = start_i ? '0 : busy_q ? {q_q[QBITS-2:0], ge} : q_q;
    cnt_d  = start_i ? '0 : busy_q ? cnt_q + 4'd1 : cnt_q;
    busy_d = start_i ? 1'b1 : done_o ? 1'b0 : busy_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      d_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      d_q    <= d_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/hp_divider.sv
// hp_divider: sequential half-precision divider (hp_inA / hp_inB) with valid/ready handshakes,
// truncating result and multiplier-compatible exception codes.
module hp_divider
  import hp_fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] hp_inA,
  input  logic [15:0] hp_inB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] hp_quotient,
  output logic [1:0]  Exceptions
);
  hp_state_t        state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [15:0]      res_q, res_d;
  logic [1:0]       exc_q, exc_d, exc_n;
  hp_class_t        ca, cb;
  logic             inv, special, accept, div_start, div_busy, div_done;
  logic [QBITS-1:0] q;
  logic signed [6:0] e_raw, e_n;
  logic [MAN_W-1:0] man_n;
  assign ca          = hp_classify(hp_inA);
  assign cb          = hp_classify(hp_inB);
  assign inv         = ca.inf | ca.nan | cb.inf | cb.nan | ca.denorm | cb.denorm | cb.zero;
  assign special     = inv | ca.zero;
  assign in_ready    = state_q == S_IDLE && !div_busy;
  assign accept      = in_valid && in_ready;
  assign div_start   = accept && !special;
  assign out_valid   = state_q == S_DONE;
  assign hp_quotient = res_q;
  assign Exceptions  = exc_q;
  hp_sig_divider u_sig (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .man_a_i (hp_inA[MAN_W-1:0]),
    .man_b_i (hp_inB[MAN_W-1:0]),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .q_o     (q)
  );
  // a quotient below 1.0 needs one left shift, paid for by the exponent
  assign e_raw = 7'({2'b00, ea_q}) - 7'({2'b00, eb_q}) + 7'(BIAS);
  assign e_n   = q[QBITS-1] ? e_raw : e_raw - 7'sd1;
  assign man_n = q[QBITS-1] ? q[QBITS-2:1] : q[QBITS-3:0];
  assign exc_n = (e_n < 7'sd1) ? EXC_UNF : (e_n > 7'sd30) ? EXC_OVF : EXC_NONE;
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    res_d   = res_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: if (accept) begin
        sign_d  = hp_inA[15] ^ hp_inB[15];
        ea_d    = hp_inA[14:10];
        eb_d    = hp_inB[14:10];
        res_d   = '0;
        exc_d   = inv ? EXC_INV : EXC_NONE;
        state_d = special ? S_DONE : S_DIV;
      end
      S_DIV:  state_d = div_done ? S_NORM : S_DIV;
      S_NORM: begin
        exc_d   = exc_n;
        res_d   = exc_n == EXC_NONE ? {sign_q, e_n[4:0], man_n} : '0;
        state_d = S_DONE;
      end
      default: state_d = out_ready ? S_IDLE : S_DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      res_q   <= '0;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end
endmodule
